// File: rtl/gshare_if.sv
// Fetch-side predict bus and resolution-side update bus of the gshare predictor.
interface gshare_if #(
    parameter int DBITS    = 32,
    parameter int BHR_BITS = 8
);
    logic                fe_valid;
    logic [DBITS-1:0]    fe_pc;
    logic                pred_dir;
    logic                btb_hit;
    logic                pred_taken;
    logic [DBITS-1:0]    pred_target;
    logic                upd_valid;
    logic [DBITS-1:0]    upd_pc;
    logic                upd_cond;
    logic                upd_taken;
    logic [DBITS-1:0]    upd_target;
    logic [BHR_BITS-1:0] bhr_out;

    modport master (
        output fe_valid, fe_pc, upd_valid, upd_pc, upd_cond, upd_taken, upd_target,
        input  pred_dir, btb_hit, pred_taken, pred_target, bhr_out
    );
    modport slave (
        input  fe_valid, fe_pc, upd_valid, upd_pc, upd_cond, upd_taken, upd_target,
        output pred_dir, btb_hit, pred_taken, pred_target, bhr_out
    );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare direction predictor (2-bit PHT indexed by PC^BHR) with a direct-mapped BTB.
// Prediction is combinational; training lands at the clock edge ending the update cycle.
module gshare_predictor #(
    parameter int DBITS        = 32,
    parameter int BHR_BITS     = 8,
    parameter int BTB_IDX_BITS = 4
) (
    input  logic     clk,
    input  logic     reset,
    gshare_if.slave  bp
);
    localparam int PHT_N = 1 << BHR_BITS;
    localparam int BTB_N = 1 << BTB_IDX_BITS;
    localparam int TAG_W = DBITS - BTB_IDX_BITS - 2;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [DBITS-1:0] target;
        logic             cond;
    } btb_entry_t;

    logic [1:0]          pht_q [PHT_N];
    btb_entry_t          btb_q [BTB_N];
    logic [BHR_BITS-1:0] bhr_q, bhr_d;
    logic [1:0]          ctr_d;

    // predict path
    logic [BHR_BITS-1:0]     fe_idx;
    logic [BTB_IDX_BITS-1:0] fe_bidx;
    btb_entry_t              fe_ent;
    logic                    raw_dir, raw_hit;
    logic [DBITS-1:0]        fe_pc_p4;

    assign fe_idx   = bp.fe_pc[BHR_BITS+1:2] ^ bhr_q;
    assign fe_bidx  = bp.fe_pc[BTB_IDX_BITS+1:2];
    assign fe_ent   = btb_q[fe_bidx];
    assign raw_dir  = pht_q[fe_idx][1];
    assign raw_hit  = fe_ent.valid && (fe_ent.tag == bp.fe_pc[DBITS-1:BTB_IDX_BITS+2]);
    assign fe_pc_p4 = bp.fe_pc + DBITS'(4);

    // Outputs are masked while reset is high so they are defined before the first reset edge.
    assign bp.pred_dir    = !reset && raw_dir;
    assign bp.btb_hit     = !reset && raw_hit;
    assign bp.pred_taken  = !reset && bp.fe_valid && raw_hit && (!fe_ent.cond || raw_dir);
    assign bp.pred_target = bp.pred_taken ? fe_ent.target : fe_pc_p4;
    assign bp.bhr_out     = reset ? '0 : bhr_q;

    // update path
    logic [BHR_BITS-1:0]     upd_idx;
    logic [BTB_IDX_BITS-1:0] upd_bidx;
    logic [1:0]              upd_ctr;
    logic                    unused_upd_lsb;

    assign upd_idx        = bp.upd_pc[BHR_BITS+1:2] ^ bhr_q;
    assign upd_bidx       = bp.upd_pc[BTB_IDX_BITS+1:2];
    assign upd_ctr        = pht_q[upd_idx];
    assign unused_upd_lsb = ^bp.upd_pc[1:0];

    always_comb begin
        ctr_d = upd_ctr;
        if (bp.upd_taken) begin
            if (upd_ctr != 2'b11) ctr_d = upd_ctr + 2'd1;
        end else begin
            if (upd_ctr != 2'b00) ctr_d = upd_ctr - 2'd1;
        end
        bhr_d = {bhr_q[BHR_BITS-2:0], bp.upd_taken};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bhr_q <= '0;
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
            for (int i = 0; i < BTB_N; i++) btb_q[i].valid <= 1'b0;
        end else if (bp.upd_valid) begin
            btb_q[upd_bidx] <= '{valid:  1'b1,
                                 tag:    bp.upd_pc[DBITS-1:BTB_IDX_BITS+2],
                                 target: bp.upd_target,
                                 cond:   bp.upd_cond};
            if (bp.upd_cond) begin
                pht_q[upd_idx] <= ctr_d;
                bhr_q          <= bhr_d;
            end
        end
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// Randomized + directed bench for gshare_predictor against an arithmetic reference model.
module tb_gshare_predictor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gshare_if #(.DBITS(32), .BHR_BITS(8)) bp ();
    gshare_predictor #(.DBITS(32), .BHR_BITS(8), .BTB_IDX_BITS(4)) dut (
        .clk(clk), .reset(reset), .bp(bp)
    );

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int unsigned m_pht [256];
    int unsigned m_bhr;
    bit          m_bv  [16];
    int unsigned m_btag[16];
    int unsigned m_btgt[16];
    bit          m_bc  [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        for (int i = 0; i < 16; i++) m_bv[i] = 0;
        m_bhr = 0;
    endfunction

    function automatic int unsigned pidx(input int unsigned pc);
        return ((pc / 4) % 256) ^ m_bhr;
    endfunction

    function automatic void m_update(input int unsigned pc, input bit c, input bit t,
                                     input int unsigned tgt);
        int unsigned b, i;
        b = (pc / 4) % 16;
        m_bv[b] = 1; m_btag[b] = pc / 64; m_btgt[b] = tgt; m_bc[b] = c;
        if (c) begin
            i = pidx(pc);
            if (t && m_pht[i] < 3) m_pht[i]++;
            if (!t && m_pht[i] > 0) m_pht[i]--;
            m_bhr = ((m_bhr * 2) + t) % 256;
        end
    endfunction

    task automatic drive(input bit fv, input int unsigned fpc, input bit uv,
                         input int unsigned upc, input bit uc, input bit ut,
                         input int unsigned utgt);
        bp.fe_valid = fv; bp.fe_pc = fpc;
        bp.upd_valid = uv; bp.upd_pc = upc; bp.upd_cond = uc;
        bp.upd_taken = ut; bp.upd_target = utgt;
    endtask

    // one cycle: compare outputs mid-cycle, then advance the model with the clock edge
    task automatic cycle();
        int unsigned pc, b, e_tgt;
        bit e_dir, e_hit, e_tk;
        @(negedge clk);
        pc = bp.fe_pc;
        b  = (pc / 4) % 16;
        if (reset) begin
            e_dir = 0; e_hit = 0; e_tk = 0;
        end else begin
            e_dir = m_pht[pidx(pc)] >= 2;
            e_hit = m_bv[b] && (m_btag[b] == pc / 64);
            e_tk  = bp.fe_valid && e_hit && (!m_bc[b] || e_dir);
        end
        e_tgt = e_tk ? m_btgt[b] : pc + 4;
        chk("pred_dir",    bp.pred_dir,    e_dir);
        chk("btb_hit",     bp.btb_hit,     e_hit);
        chk("pred_taken",  bp.pred_taken,  e_tk);
        chk("pred_target", bp.pred_target, e_tgt);
        chk("bhr_out",     bp.bhr_out,     reset ? 0 : m_bhr);
        @(posedge clk);
        if (reset) m_reset();
        else if (bp.upd_valid) m_update(bp.upd_pc, bp.upd_cond, bp.upd_taken, bp.upd_target);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        cycle();
        reset = 1'b0;
    endtask

    function automatic int unsigned rnd_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return ($urandom_range(0, 3) << 28) | ($urandom_range(0, 255) << 2);
    endfunction

    initial begin
        reset = 1'b1;
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        cycle();
        reset = 1'b0;

        // reset state
        drive(1, 32'h100, 0, 0, 0, 0, 0);
        #1 chk("rst_target", bp.pred_target, 32'h104);
        cycle();

        // jump training
        drive(1, 32'h100, 1, 32'h200, 0, 0, 32'h300);
        cycle();
        drive(1, 32'h200, 0, 0, 0, 0, 0);
        #1 chk("jmp_target", bp.pred_target, 32'h300);
        chk("jmp_bhr", bp.bhr_out, 8'h00);
        cycle();

        // gshare indexing
        do_reset();
        drive(1, 32'h100, 1, 32'h40, 1, 1, 32'h10);
        cycle();
        drive(1, 32'h40, 0, 0, 0, 0, 0);
        #1 chk("gs_bhr", bp.bhr_out, 8'h01);
        chk("gs_taken", bp.pred_taken, 1'b0);
        chk("gs_target", bp.pred_target, 32'h44);
        cycle();

        // saturation
        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(0, 32'h0, 1, 32'h3FC, 1, 1, 32'h80);
            cycle();
        end
        drive(0, 32'h0, 1, 32'h3FC, 1, 0, 32'h80);
        cycle();
        drive(1, 32'h3F8, 0, 0, 0, 0, 0);
        #1 chk("sat_dir", bp.pred_dir, 1'b1);
        chk("sat_bhr", bp.bhr_out, 8'hFE);
        cycle();

        // same-cycle conflict, then PC wrap
        drive(1, 32'h500, 1, 32'h500, 0, 0, 32'h600);
        #1 chk("conf_hit0", bp.btb_hit, 1'b0);
        cycle();
        drive(1, 32'h500, 0, 0, 0, 0, 0);
        #1 chk("conf_tgt1", bp.pred_target, 32'h600);
        cycle();
        drive(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        #1 chk("wrap_tgt", bp.pred_target, 32'h0);
        cycle();

        // reset mid-operation
        drive(1, 32'h0, 1, 32'h200, 0, 0, 32'h300);
        cycle();
        reset = 1'b1;
        drive(1, 32'h200, 1, 32'h700, 0, 0, 32'h900);
        cycle();
        reset = 1'b0;
        drive(1, 32'h200, 0, 0, 0, 0, 0);
        #1 chk("mid_hit200", bp.btb_hit, 1'b0);
        cycle();
        drive(1, 32'h700, 0, 0, 0, 0, 0);
        #1 chk("mid_hit700", bp.btb_hit, 1'b0);
        cycle();

        // randomized traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            int unsigned p;
            p = rnd_pc();
            reset = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) != 0) ? p : rnd_pc(),
                  $urandom_range(0, 1) != 0, rnd_pc(),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, $urandom() & ~32'h3);
            cycle();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
